dmem_responder: RTL

Data-memory responder for the pipelined processor's MEM stage. It accepts the MEM stage's load/store request (address = ALU result, write data = second register operand), holds it for a programmable number of wait cycles, then commits the write or returns read data with a one-cycle `ready` pulse. While a request is outstanding it drives `stall` so the pipeline freezes the EX/MEM register.

---
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_responder.sv | 83 ++++++++
 2 files changed

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage load/store request and response bundle
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        addr_err;
    logic        stall;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, addr_err, stall
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, addr_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: latency-programmable data memory with stall/ready handshake
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          req_err;
    logic          idle_commit;
    logic          commit;
    logic          c_rd;
    logic          c_wr;
    logic          c_err;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;

    assign req       = bus.mem_read | bus.mem_write;
    assign req_err   = (bus.addr[1:0] != 2'b00)
                     || ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS))
                     || (bus.mem_read && bus.mem_write);
    assign bus.stall = req & ~bus.ready;

    // With zero latency the commit edge is the acceptance edge, so the live request is used
    assign idle_commit = (state == IDLE) && req && (LATENCY == 0);
    assign commit      = rst && (idle_commit || (state == BUSY && cnt == 4'd1));
    assign c_rd        = idle_commit ? bus.mem_read         : rd_q;
    assign c_wr        = idle_commit ? bus.mem_write        : wr_q;
    assign c_err       = idle_commit ? req_err              : err_q;
    assign c_idx       = idle_commit ? bus.addr[AW+1:2]     : idx_q;
    assign c_wdata     = idle_commit ? bus.wdata            : wdata_q;

    // Array write on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && c_wr && !c_err) mem[c_idx] <= c_wdata;
    end

    // Request FSM: latch at acceptance, count down the latency, pulse ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.ready    <= 1'b0;
            bus.addr_err <= 1'b0;
            bus.rdata    <= '0;
        end else begin
            bus.ready    <= commit;
            bus.addr_err <= commit && c_err;
            if (commit && (c_err || c_rd)) bus.rdata <= c_err ? '0 : mem[c_idx];
            case (state)
                IDLE: if (req) begin
                    idx_q   <= bus.addr[AW+1:2];
                    wdata_q <= bus.wdata;
                    rd_q    <= bus.mem_read;
                    wr_q    <= bus.mem_write;
                    err_q   <= req_err;
                    cnt     <= 4'(LATENCY);
                    state   <= (LATENCY == 0) ? RESP : BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
